atm_txn_ctrl: RTL and testbench

Transaction sequencer that owns the 16 x 32-bit account register file and performs read-modify-write account operations (balance query, deposit, withdraw) requested by the ATM front-end. It accepts one request at a time over a valid/ready handshake, drives the register file's select, write-enable and write-data inputs, checks funds and overflow, and returns the resulting balance and a status code over a valid/ready response channel. It sits between the keypad/command decoder and the register file, and is the only master of the register file.

---
 rtl/atm_txn_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_atm_txn_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/atm_txn_ctrl.sv
// ---------------------------------------------------------------------------
// atm_txn_ctrl
//
// Transaction sequencer for the 16 x 32-bit account register file. It accepts
// one request at a time (query / deposit / withdraw), reads the account and
// checks funds and overflow. On success it writes the new balance back. It
// always returns a balance and a status code on the response channel. This
// block is the only master of the register file.
//
// Ports:
//   clk, rst                  system clock, asynchronous active-high reset
//   req_valid/req_ready       request handshake
//   req_op                    00 query, 01 deposit, 10 withdraw, 11 reserved
//   req_acct, req_amt         account index and unsigned amount
//   resp_valid/resp_ready     response handshake
//   resp_balance, resp_err    resulting balance; 00 ok, 01 funds, 10 overflow,
//                             11 limit exceeded or bad op
//   rf_en, rf_sel, rf_wdata   register file write enable / select / data
//   rf_rdata                  register file read data (one cycle after select)
//   txn_count                 committed writes, saturating
//
// Optional feature macro: ATM_TXN_LIMIT_EN enables the per-transaction
// withdraw limit WD_LIMIT. When it is undefined, WD_LIMIT is unused.
// ---------------------------------------------------------------------------
module atm_txn_ctrl #(
   parameter int                DATA_W   = 32,
   parameter int                ADDR_W   = 4,
   parameter logic [DATA_W-1:0] WD_LIMIT = DATA_W'(500)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic [ADDR_W-1:0] req_acct,
   input  logic [DATA_W-1:0] req_amt,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_balance,
   output logic [1:0]        resp_err,
   output logic              rf_en,
   output logic [ADDR_W-1:0] rf_sel,
   output logic [DATA_W-1:0] rf_wdata,
   input  logic [DATA_W-1:0] rf_rdata,
   output logic [15:0]       txn_count
);

   // state  | meaning
   // IDLE   | waiting for a request, req_ready high
   // RD     | account selected on rf_sel, read in flight
   // CALC   | old balance on rf_rdata, checks evaluated
   // WR     | rf_en high, new balance written
   // RESP   | response held until resp_ready
   typedef enum logic [2:0] {S_IDLE, S_RD, S_CALC, S_WR, S_RESP} state_t;

   localparam logic [1:0] OP_QRY = 2'b00;
   localparam logic [1:0] OP_DEP = 2'b01;
   localparam logic [1:0] OP_WD  = 2'b10;
   localparam logic [1:0] OP_BAD = 2'b11;

   localparam logic [1:0] ERR_OK    = 2'b00;
   localparam logic [1:0] ERR_FUNDS = 2'b01;
   localparam logic [1:0] ERR_OVF   = 2'b10;
   localparam logic [1:0] ERR_LIMIT = 2'b11;

   state_t              state_q;
   logic [1:0]          op_q;
   logic [DATA_W-1:0]   amt_q;
   logic                req_ready_q;
   logic                resp_valid_q;
   logic [DATA_W-1:0]   resp_balance_q;
   logic [1:0]          resp_err_q;
   logic                rf_en_q;
   logic [ADDR_W-1:0]   rf_sel_q;
   logic [DATA_W-1:0]   rf_wdata_q;
   logic [15:0]         txn_count_q;

   logic [DATA_W:0]     sum_d;
   logic [DATA_W-1:0]   diff_d;
   logic                over_limit_d;

   // The extra sum bit is the carry out used for overflow detection.
   always_comb begin
      sum_d  = {1'b0, rf_rdata} + {1'b0, amt_q};
      diff_d = rf_rdata - amt_q;
   end

`ifdef ATM_TXN_LIMIT_EN
   assign over_limit_d = (amt_q > WD_LIMIT);
`else
   assign over_limit_d = 1'b0;
   logic wd_limit_unused;
   assign wd_limit_unused = ^WD_LIMIT;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= S_IDLE;
         op_q           <= OP_QRY;
         amt_q          <= '0;
         req_ready_q    <= 1'b0;
         resp_valid_q   <= 1'b0;
         resp_balance_q <= '0;
         resp_err_q     <= ERR_OK;
         rf_en_q        <= 1'b0;
         rf_sel_q       <= '0;
         rf_wdata_q     <= '0;
         txn_count_q    <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               // req_ready comes up one cycle after reset release
               if (req_valid && req_ready_q) begin
                  op_q        <= req_op;
                  amt_q       <= req_amt;
                  rf_sel_q    <= req_acct;
                  req_ready_q <= 1'b0;
                  state_q     <= S_RD;
               end else begin
                  req_ready_q <= 1'b1;
               end
            end
            S_RD: begin
               state_q <= S_CALC;
            end
            S_CALC: begin
               resp_balance_q <= rf_rdata;
               if (op_q == OP_BAD || (op_q == OP_WD && over_limit_d)) begin
                  resp_err_q   <= ERR_LIMIT;
                  resp_valid_q <= 1'b1;
                  state_q      <= S_RESP;
               end else if (op_q == OP_WD && amt_q > rf_rdata) begin
                  resp_err_q   <= ERR_FUNDS;
                  resp_valid_q <= 1'b1;
                  state_q      <= S_RESP;
               end else if (op_q == OP_DEP && sum_d[DATA_W]) begin
                  resp_err_q   <= ERR_OVF;
                  resp_valid_q <= 1'b1;
                  state_q      <= S_RESP;
               end else if (op_q == OP_QRY) begin
                  resp_err_q   <= ERR_OK;
                  resp_valid_q <= 1'b1;
                  state_q      <= S_RESP;
               end else begin
                  rf_en_q    <= 1'b1;
                  rf_wdata_q <= (op_q == OP_DEP) ? sum_d[DATA_W-1:0] : diff_d;
                  state_q    <= S_WR;
               end
            end
            S_WR: begin
               rf_en_q        <= 1'b0;
               resp_balance_q <= rf_wdata_q;
               resp_err_q     <= ERR_OK;
               resp_valid_q   <= 1'b1;
               if (txn_count_q != 16'hFFFF)
                  txn_count_q <= txn_count_q + 16'd1;
               state_q        <= S_RESP;
            end
            S_RESP: begin
               if (resp_ready) begin
                  resp_valid_q <= 1'b0;
                  req_ready_q  <= 1'b1;
                  state_q      <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign req_ready    = req_ready_q;
   assign resp_valid   = resp_valid_q;
   assign resp_balance = resp_balance_q;
   assign resp_err     = resp_err_q;
   assign rf_en        = rf_en_q;
   assign rf_sel       = rf_sel_q;
   assign rf_wdata     = rf_wdata_q;
   assign txn_count    = txn_count_q;

endmodule

// File: tb/tb_atm_txn_ctrl.sv
// Bench for atm_txn_ctrl: behavioural register file, an independent balance
// model and a response scoreboard queue.
module tb_atm_txn_ctrl;

`ifdef ATM_TXN_LIMIT_EN
   localparam bit LIMIT_EN = 1'b1;
`else
   localparam bit LIMIT_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [3:0]  req_acct;
   logic [31:0] req_amt;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_balance;
   logic [1:0]  resp_err;
   logic        rf_en;
   logic [3:0]  rf_sel;
   logic [31:0] rf_wdata;
   logic [31:0] rf_rdata;
   logic [15:0] txn_count;

   int checks = 0;
   int errors = 0;

   logic [33:0] sb_q[$];
   logic [31:0] model_bal [16];
   int          model_cnt;
   logic [31:0] rf_mem [16];

   always #5 clk = ~clk;

   atm_txn_ctrl dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_acct(req_acct), .req_amt(req_amt),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_balance(resp_balance), .resp_err(resp_err),
      .rf_en(rf_en), .rf_sel(rf_sel), .rf_wdata(rf_wdata),
      .rf_rdata(rf_rdata), .txn_count(txn_count)
   );

   // Register file: synchronous read, cleared by the shared reset.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) rf_mem[i] <= '0;
         rf_rdata <= '0;
      end else begin
         if (rf_en) rf_mem[rf_sel] <= rf_wdata;
         rf_rdata <= rf_mem[rf_sel];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, " req_ready"},    {31'd0, req_ready}, 32'd0);
      chk({tag, " resp_valid"},   {31'd0, resp_valid}, 32'd0);
      chk({tag, " resp_balance"}, resp_balance, 32'd0);
      chk({tag, " resp_err"},     {30'd0, resp_err}, 32'd0);
      chk({tag, " rf_en"},        {31'd0, rf_en}, 32'd0);
      chk({tag, " rf_sel"},       {28'd0, rf_sel}, 32'd0);
      chk({tag, " rf_wdata"},     rf_wdata, 32'd0);
      chk({tag, " txn_count"},    {16'd0, txn_count}, 32'd0);
   endtask

   // Waits for req_ready with a bounded budget; called at a negedge.
   task automatic wait_ready(input string tag);
      int n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, " req_ready_wait"}, {31'd0, req_ready}, 32'd1);
   endtask

   // One transaction: push the model's expectation, drive, follow the DUT
   // cycle by cycle, then pop and compare. hold > 0 applies backpressure
   // for that many cycles while a stray request is presented.
   task automatic txn(input string tag, input logic [1:0] op, input logic [3:0] acct,
                      input logic [31:0] amt, input int hold);
      logic [31:0] old_bal, exp_bal, snap_bal;
      logic [1:0]  exp_err, snap_err;
      logic [32:0] sum;
      logic [33:0] exp_item;
      bit          wr, sel_ok, stable;
      int          cyc, wr_cnt;

      old_bal = model_bal[acct];
      sum     = {1'b0, old_bal} + {1'b0, amt};
      wr      = 1'b0;
      exp_bal = old_bal;
      if (op == 2'b11)                                 exp_err = 2'b11;
      else if (op == 2'b10 && LIMIT_EN && amt > 32'd500) exp_err = 2'b11;
      else if (op == 2'b10 && amt > old_bal)           exp_err = 2'b01;
      else if (op == 2'b01 && sum[32])                 exp_err = 2'b10;
      else if (op == 2'b00)                            exp_err = 2'b00;
      else begin
         exp_err = 2'b00;
         wr      = 1'b1;
         exp_bal = (op == 2'b01) ? sum[31:0] : old_bal - amt;
         model_bal[acct] = exp_bal;
         if (model_cnt < 65535) model_cnt++;
      end
      sb_q.push_back({exp_bal, exp_err});

      wait_ready(tag);
      resp_ready = (hold == 0);
      req_valid  = 1'b1;
      req_op     = op;
      req_acct   = acct;
      req_amt    = amt;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;

      cyc    = 1;
      wr_cnt = 0;
      sel_ok = 1'b1;
      while (!resp_valid && cyc < 20) begin
         if (rf_en) begin
            wr_cnt++;
            if (rf_sel !== acct) sel_ok = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      if (rf_en) wr_cnt++;
      chk({tag, " latency"}, cyc, wr ? 32'd4 : 32'd3);
      chk({tag, " write_cycles"}, wr_cnt, wr ? 32'd1 : 32'd0);
      chk({tag, " write_sel"}, {31'd0, sel_ok}, 32'd1);

      if (sb_q.size() > 0) begin
         exp_item = sb_q.pop_front();
         chk({tag, " balance"}, resp_balance, exp_item[33:2]);
         chk({tag, " err"}, {30'd0, resp_err}, {30'd0, exp_item[1:0]});
      end else begin
         chk({tag, " scoreboard_empty"}, 32'd1, 32'd0);
      end
      chk({tag, " txn_count"}, {16'd0, txn_count}, model_cnt);

      if (hold > 0) begin
         snap_bal = resp_balance;
         snap_err = resp_err;
         stable   = 1'b1;
         req_valid = 1'b1;
         req_op    = 2'b01;
         req_acct  = acct;
         req_amt   = 32'd999;
         repeat (hold) begin
            @(negedge clk);
            if (!resp_valid || resp_balance !== snap_bal || resp_err !== snap_err || req_ready)
               stable = 1'b0;
         end
         req_valid = 1'b0;
         chk({tag, " hold_stable"}, {31'd0, stable}, 32'd1);
         resp_ready = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      chk({tag, " resp_released"}, {31'd0, resp_valid}, 32'd0);
   endtask

   initial begin
      bit seen;
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_op     = 2'b00;
      req_acct   = 4'd0;
      req_amt    = 32'd0;
      resp_ready = 1'b1;
      for (int i = 0; i < 16; i++) model_bal[i] = 32'd0;
      model_cnt = 0;

      repeat (3) @(negedge clk);
      chk_reset_outputs("reset");
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("post_reset req_ready", {31'd0, req_ready}, 32'd1);

      txn("query3",      2'b00, 4'd3, 32'd0,   0);
      txn("dep100",      2'b01, 4'd5, 32'd100, 0);
      txn("wd40",        2'b10, 4'd5, 32'd40,  0);
      txn("wd61_funds",  2'b10, 4'd5, 32'd61,  0);
      txn("query5",      2'b00, 4'd5, 32'd7,   0);
      txn("dep_max",     2'b01, 4'd7, 32'hFFFF_FFFF, 0);
      txn("dep1_ovf",    2'b01, 4'd7, 32'd1,   0);
      txn("dep0",        2'b01, 4'd7, 32'd0,   0);
      txn("wd_all",      2'b10, 4'd7, 32'hFFFF_FFFF, 0);
      txn("bad_op",      2'b11, 4'd2, 32'd10,  0);
      txn("dep1000",     2'b01, 4'd9, 32'd1000, 0);
      txn("wd501",       2'b10, 4'd9, 32'd501, 0);
      txn("dep5_hold",   2'b01, 4'd1, 32'd5,   10);
      txn("query1",      2'b00, 4'd1, 32'd0,   0);

      // Reset while the write is in flight.
      wait_ready("rst_wr");
      req_valid = 1'b1;
      req_op    = 2'b01;
      req_acct  = 4'd4;
      req_amt   = 32'd50;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_wr rf_en_before", {31'd0, rf_en}, 32'd1);
      rst = 1'b1;
      #1;
      chk_reset_outputs("rst_wr");
      for (int i = 0; i < 16; i++) model_bal[i] = 32'd0;
      model_cnt = 0;
      @(negedge clk);
      rst  = 1'b0;
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (resp_valid) seen = 1'b1;
      end
      chk("rst_wr no_response", {31'd0, seen}, 32'd0);

      txn("query4_after_rst", 2'b00, 4'd4, 32'd0, 0);
      txn("query5_after_rst", 2'b00, 4'd5, 32'd0, 0);
      chk("scoreboard_drained", sb_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
